// File: rtl/transpose_pingpong_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : transpose_pingpong_buffer_if
// Description : Row-write / column-read handshake bundle for the transpose
//               ping-pong buffer. Optional i_transpose under TPB_MODE_SEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface transpose_pingpong_buffer_if #(
    parameter int DATA_W = 12,
    parameter int N      = 8
);
    logic                i_wr_valid;
    logic                o_wr_ready;
    logic [N*DATA_W-1:0] i_wr_data;
    logic                o_wr_last;
    logic                o_rd_valid;
    logic                i_rd_ready;
    logic [N*DATA_W-1:0] o_rd_data;
    logic                o_rd_last;
`ifdef TPB_MODE_SEL_EN
    logic                i_transpose;

    modport master (
        output i_wr_valid, i_wr_data, i_rd_ready, i_transpose,
        input  o_wr_ready, o_wr_last, o_rd_valid, o_rd_data, o_rd_last
    );
    modport slave (
        input  i_wr_valid, i_wr_data, i_rd_ready, i_transpose,
        output o_wr_ready, o_wr_last, o_rd_valid, o_rd_data, o_rd_last
    );
`else
    modport master (
        output i_wr_valid, i_wr_data, i_rd_ready,
        input  o_wr_ready, o_wr_last, o_rd_valid, o_rd_data, o_rd_last
    );
    modport slave (
        input  i_wr_valid, i_wr_data, i_rd_ready,
        output o_wr_ready, o_wr_last, o_rd_valid, o_rd_data, o_rd_last
    );
`endif
endinterface
`default_nettype wire

// File: rtl/transpose_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module      : transpose_pingpong_buffer
// Description : N x N block transposer with two ping-pong banks; rows in,
//               columns out. Macro TPB_MODE_SEL_EN adds per-block row/column
//               read selection via i_transpose.
// Revision    : 1.0 - initial release
// ============================================================================
module transpose_pingpong_buffer #(
    parameter int DATA_W = 12,
    parameter int N      = 8
) (
    input logic                        i_clk,
    input logic                        i_rst,
    transpose_pingpong_buffer_if.slave bus
);
    localparam int              CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(N - 1);

    // Sample storage is intentionally not reset; only the full flags gate use.
    logic [DATA_W-1:0] mem_q [2][N][N];

    logic             wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0] wr_row_q,  wr_row_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] rd_col_q,  rd_col_d;
    logic [1:0]       full_q,    full_d;
`ifdef TPB_MODE_SEL_EN
    logic [1:0]       mode_q,    mode_d;
`endif

    logic                w_wr_ready;
    logic                w_rd_valid;
    logic                w_wr_fire;
    logic                w_rd_fire;
    logic [N*DATA_W-1:0] w_rd_data;

    assign w_wr_ready = ~full_q[wr_bank_q];
    assign w_rd_valid = full_q[rd_bank_q];
    assign w_wr_fire  = bus.i_wr_valid & w_wr_ready;
    assign w_rd_fire  = w_rd_valid & bus.i_rd_ready;

    assign bus.o_wr_ready = w_wr_ready;
    assign bus.o_wr_last  = (wr_row_q == c_last);
    assign bus.o_rd_valid = w_rd_valid;
    assign bus.o_rd_last  = w_rd_valid & (rd_col_q == c_last);
    assign bus.o_rd_data  = w_rd_data;

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;
        full_d    = full_q;
`ifdef TPB_MODE_SEL_EN
        mode_d    = mode_q;
`endif
        // Read and write always target different banks, so both may commit.
        if (w_rd_fire) begin
            if (rd_col_q == c_last) begin
                rd_col_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_col_d = rd_col_q + 1'b1;
            end
        end
        if (w_wr_fire) begin
`ifdef TPB_MODE_SEL_EN
            if (wr_row_q == '0) begin
                mode_d[wr_bank_q] = bus.i_transpose;
            end
`endif
            if (wr_row_q == c_last) begin
                wr_row_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_row_d = wr_row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= '0;
            full_q    <= 2'b00;
`ifdef TPB_MODE_SEL_EN
            mode_q    <= 2'b11;
`endif
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
            full_q    <= full_d;
`ifdef TPB_MODE_SEL_EN
            mode_q    <= mode_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            for (int c = 0; c < N; c++) begin
                mem_q[wr_bank_q][wr_row_q][c] <= bus.i_wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (w_rd_valid) begin
            for (int r = 0; r < N; r++) begin
`ifdef TPB_MODE_SEL_EN
                if (mode_q[rd_bank_q]) begin
                    w_rd_data[r*DATA_W +: DATA_W] = mem_q[rd_bank_q][r][rd_col_q];
                end else begin
                    w_rd_data[r*DATA_W +: DATA_W] = mem_q[rd_bank_q][rd_col_q][r];
                end
`else
                w_rd_data[r*DATA_W +: DATA_W] = mem_q[rd_bank_q][r][rd_col_q];
`endif
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_transpose_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_transpose_pingpong_buffer
// Description : Randomised self-checking bench with a queue-of-blocks model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_transpose_pingpong_buffer;
    localparam int DW = 12;
    localparam int N  = 8;

    typedef logic [N*N*DW-1:0] blk_t;
    typedef logic [N*DW-1:0]   beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    transpose_pingpong_buffer_if #(.DATA_W(DW), .N(N)) bus ();

    transpose_pingpong_buffer #(.DATA_W(DW), .N(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Model: completed blocks awaiting drain, plus the block being assembled.
    blk_t pend[$];
    blk_t cur = '0;
    int   m_wr_row = 0;
    int   m_rd_col = 0;

    function automatic beat_t exp_rd_data();
        beat_t d = '0;
        if (pend.size() > 0) begin
            for (int r = 0; r < N; r++) d[r*DW +: DW] = pend[0][(r*N + m_rd_col)*DW +: DW];
        end
        return d;
    endfunction

    task automatic check(input string name, input beat_t act, input beat_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit wf, rf;
        if (rst) begin
            pend.delete();
            m_wr_row = 0;
            m_rd_col = 0;
        end else begin
            wf = bus.i_wr_valid && (pend.size() < 2);
            rf = bus.i_rd_ready && (pend.size() > 0);
            if (rf) begin
                m_rd_col++;
                if (m_rd_col == N) begin
                    void'(pend.pop_front());
                    m_rd_col = 0;
                end
            end
            if (wf) begin
                for (int c = 0; c < N; c++) cur[(m_wr_row*N + c)*DW +: DW] = bus.i_wr_data[c*DW +: DW];
                m_wr_row++;
                if (m_wr_row == N) begin
                    pend.push_back(cur);
                    m_wr_row = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_ready", beat_t'(bus.o_wr_ready), beat_t'(pend.size() < 2));
            check("rd_valid", beat_t'(bus.o_rd_valid), beat_t'(pend.size() > 0));
            check("wr_last",  beat_t'(bus.o_wr_last),  beat_t'(m_wr_row == N-1));
            check("rd_last",  beat_t'(bus.o_rd_last),  beat_t'((pend.size() > 0) && (m_rd_col == N-1)));
            check("rd_data",  bus.o_rd_data, exp_rd_data());
        end
    end

    function automatic beat_t pattern_row(input int r);
        beat_t d = '0;
        for (int c = 0; c < N; c++) d[c*DW +: DW] = DW'(r*16 + c);
        return d;
    endfunction

    function automatic beat_t rand_beat();
        beat_t d;
        for (int c = 0; c < N; c++) d[c*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    initial begin
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_rd_ready = 1'b0;
`ifdef TPB_MODE_SEL_EN
        bus.i_transpose = 1'b1;
`endif
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk); #1;
        check("rst_wr_ready", beat_t'(bus.o_wr_ready), beat_t'(1));
        check("rst_rd_valid", beat_t'(bus.o_rd_valid), beat_t'(0));
        check("rst_rd_data",  bus.o_rd_data, beat_t'(0));

        // Directed block: row r sample c = r*16+c, reader always ready.
        bus.i_rd_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            if (r > 0) begin @(negedge clk); #1; end
            if (r == N-1) check("wr_last_row7", beat_t'(bus.o_wr_last), beat_t'(1));
            bus.i_wr_valid = 1'b1;
            bus.i_wr_data  = pattern_row(r);
        end
        @(negedge clk); #1;
        bus.i_wr_valid = 1'b0;
        check("first_valid", beat_t'(bus.o_rd_valid), beat_t'(1));
        check("b0_s3", beat_t'(bus.o_rd_data[3*DW +: DW]), beat_t'(48));
        check("b0_last", beat_t'(bus.o_rd_last), beat_t'(0));
        for (int k = 1; k < N; k++) begin
            @(negedge clk); #1;
        end
        check("b7_s5", beat_t'(bus.o_rd_data[5*DW +: DW]), beat_t'(87));
        check("b7_last", beat_t'(bus.o_rd_last), beat_t'(1));

        // Random phases: mixed, streaming, backpressure, slow writer, resets.
        for (int p = 0; p < 5; p++) begin
            int wp, rp;
            case (p)
                0: begin wp = 80;  rp = 80;  end
                1: begin wp = 100; rp = 100; end
                2: begin wp = 100; rp = 15;  end
                3: begin wp = 30;  rp = 100; end
                default: begin wp = 70; rp = 60; end
            endcase
            for (int i = 0; i < 400; i++) begin
                @(negedge clk); #1;
                rst = (p == 4) && ($urandom_range(0, 99) == 0);
                bus.i_wr_valid = ($urandom_range(0, 99) < wp);
                bus.i_wr_data  = rand_beat();
                bus.i_rd_ready = ($urandom_range(0, 99) < rp);
            end
        end

        // Mid-operation reset: block 1 half drained, 5 rows of block 2 written.
        @(negedge clk); #1;
        rst = 1'b1; bus.i_wr_valid = 1'b0; bus.i_rd_ready = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        for (int r = 0; r < N; r++) begin
            bus.i_wr_valid = 1'b1;
            bus.i_wr_data  = rand_beat();
            @(negedge clk); #1;
        end
        for (int r = 0; r < 5; r++) begin
            bus.i_rd_ready = (r < 4);
            bus.i_wr_data  = rand_beat();
            @(negedge clk); #1;
        end
        rst = 1'b1; bus.i_wr_valid = 1'b0; bus.i_rd_ready = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        check("mid_rst_rd_valid", beat_t'(bus.o_rd_valid), beat_t'(0));
        check("mid_rst_wr_ready", beat_t'(bus.o_wr_ready), beat_t'(1));
        for (int r = 0; r < N; r++) begin
            bus.i_wr_valid = 1'b1;
            bus.i_wr_data  = pattern_row(r);
            @(negedge clk); #1;
        end
        bus.i_wr_valid = 1'b0;
        check("post_rst_b0_s2", beat_t'(bus.o_rd_data[2*DW +: DW]), beat_t'(32));

        bus.i_rd_ready = 1'b1;
        repeat (24) begin @(negedge clk); #1; end
        check("drained", beat_t'(bus.o_rd_valid), beat_t'(0));

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/transpose_pingpong_buffer.md
Name: transpose_pingpong_buffer

Overview:
- Parametrised successor to the team's fixed 8x8 12-bit line buffer. Accepts an N x N block as N row beats (N samples each) and emits it as N column beats, so the output is the transposed block.
- Two ping-pong banks let one block be written while the previous block drains. Valid/ready handshakes on both sides.
- Sits between the row-wise preprocessing stages and the column-wise 2-D transform stages of the accelerator.

Parameters:
- DATA_W, 12, bits per sample.
- N, 8, block dimension (samples per beat and beats per block); legal range 2..32.
- CNT_W, $clog2(N), width of the row/column counters; derived, not overridden.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_wr_valid  in  1  write beat valid.
- o_wr_ready  out  1  write beat accepted when i_wr_valid & o_wr_ready.
- i_wr_data  in  N*DATA_W  row beat; sample c occupies bits [c*DATA_W +: DATA_W].
- o_rd_valid  out  1  read beat valid.
- i_rd_ready  in  1  read beat consumed when o_rd_valid & i_rd_ready.
- o_rd_data  out  N*DATA_W  column beat; sample r (bits [r*DATA_W +: DATA_W]) = row r of the current column.
- o_rd_last  out  1  high with the final (N-1) column beat of a block.
- o_wr_last  out  1  high while the next accepted write completes a block (wr_row==N-1).

Behaviour:
- Storage: two banks, each N x N x DATA_W. Storage is not reset. Each bank has a full flag, cleared by reset.
- Write side: wr_bank (1 bit) and wr_row (CNT_W bits).
  - o_wr_ready = ~full[wr_bank].
  - Accepted beat writes row wr_row of wr_bank; wr_row increments.
  - On the accept at wr_row==N-1: wr_row wraps to 0, full[wr_bank] is set, wr_bank toggles.
- Read side: rd_bank and rd_col.
  - o_rd_valid = full[rd_bank].
  - o_rd_data sample r = bank[rd_bank][row r][col rd_col], combinational from storage.
  - o_rd_data is forced to 0 when o_rd_valid=0.
  - Accepted beat increments rd_col.
  - On the accept at rd_col==N-1: rd_col wraps to 0, full[rd_bank] is cleared, rd_bank toggles.
  - o_rd_last = o_rd_valid & (rd_col==N-1).
- Latency: first column of a block is valid on the cycle after the accept of its last row beat. Minimum is 1 cycle; there is no write-through.
- Throughput: with i_rd_ready held high and continuous writes, one beat per cycle on each side, indefinitely.
- Full/empty and simultaneous events:
  - Both banks full: o_wr_ready=0 until the reader releases a bank. Ready rises the cycle after the final read accept, never combinationally from i_rd_ready.
  - Both banks empty: o_rd_valid=0.
  - Final write to one bank and final read from the other in the same cycle: both take effect. Each bank's full flag is touched only by its own event.
  - The read side never reads the bank currently being filled (it is not full).
- Handshake rules:
  - o_rd_data and o_rd_valid remain stable while o_rd_valid & ~i_rd_ready.
  - Writes with i_wr_valid low or o_wr_ready low are ignored; no state change.
- Reset (also mid-block):
  - wr_bank, rd_bank, wr_row and rd_col are set to 0; both full flags are cleared.
  - Partial blocks are discarded.
  - Outputs on the cycle after reset: o_wr_ready=1, o_rd_valid=0, o_rd_data=0, o_rd_last=0, o_wr_last=0.
- Arithmetic: samples pass through unchanged. No sign handling or width change.

Optional Feature:
- Macro TPB_MODE_SEL_EN.
- Defined:
  - Adds input port i_transpose (1 bit).
  - The value is sampled on the first accepted write beat of a block (wr_row==0) and stored per bank.
  - When the stored bit is 0, the read side emits rows instead of columns: beat k = row k as written, sample c = column c.
  - When the stored bit is 1, behaviour is the default transpose.
- Not defined: no port added; always transposes.

Test Plan:
- Reset, then one block (N=8, DATA_W=12): write row r with sample c = r*16+c, then hold i_rd_ready=1 -> first o_rd_valid the cycle after the 8th write; read beat k has sample j = j*16+k; o_rd_last only on beat 7; o_wr_last only on write beat 7.
- Back-to-back streaming: 4 blocks written continuously with i_rd_ready=1 -> o_wr_ready never drops; 32 read beats, every value correct; banks alternate.
- Backpressure: write 3 blocks with i_rd_ready=0 -> o_wr_ready=0 after the 16th accept; o_rd_data stable; raise i_rd_ready for 8 cycles -> o_wr_ready=1 on the cycle after the 8th read accept; 3rd block then accepted and read intact.
- Simultaneous: the 8th write to bank 1 coincides with the 8th read of bank 0 -> full[1]=1, full[0]=0; next cycle read continues from bank 1, column 0.
- Reset mid-operation: assert i_rst after 5 writes of block 2 while block 1 is half drained -> next cycle o_rd_valid=0, o_wr_ready=1; a fresh block then reads correctly starting from bank 0.
- With TPB_MODE_SEL_EN: block A written with i_transpose=0, block B with 1 -> A read as rows (beat k sample c = k*16+c), B read transposed.
